// File: rtl/aoi112_pipe.sv
// Lane-wide AOI112/OAI112/AO112/OA112 complex gate behind a valid/ready register
// pipeline, with a saturating counter of changed output vectors.
module aoi112_pipe #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned STAGES = 2,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [WIDTH-1:0] c1,
    input  logic [WIDTH-1:0] c2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] toggle_cnt
);

    localparam int unsigned LAST = STAGES - 1;

    logic [WIDTH-1:0]  lane_res;
    logic [STAGES-1:0] load;
    logic              load_acc;
    logic [STAGES-1:0] v_q;
    logic [WIDTH-1:0]  d_q [STAGES];
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  last_q, last_d;
    logic              fire;

    always_comb begin
        case (mode)
            2'd0:    lane_res = ~(a1 | b1 | (c1 & c2));
            2'd1:    lane_res = ~(a1 & b1 & (c1 | c2));
            2'd2:    lane_res = a1 | b1 | (c1 & c2);
            default: lane_res = a1 & b1 & (c1 | c2);
        endcase
    end

    // load[k] = out_ready | any empty stage at or after k, accumulated from the
    // output end so the ready chain has no self-referencing vector bits.
    always_comb begin
        load     = '0;
        load_acc = out_ready;
        for (int unsigned i = 0; i < STAGES; i++) begin
            load_acc           = load_acc | ~v_q[LAST-i];
            load[LAST-i]       = load_acc;
        end
    end

    assign in_ready  = load[0];
    assign out_valid = v_q[LAST];
    assign out_data  = d_q[LAST];
    assign fire      = v_q[LAST] & out_ready;

    always_comb begin
        cnt_d  = cnt_q;
        last_d = last_q;
        if (fire) begin
            last_d = d_q[LAST];
            if ((d_q[LAST] != last_q) && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        if (cnt_clr) begin
            cnt_d = '0;
        end
    end

    assign toggle_cnt = cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q    <= '0;
            cnt_q  <= '0;
            last_q <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                d_q[k] <= '0;
            end
        end else begin
            if (load[0]) begin
                v_q[0] <= in_valid;
                d_q[0] <= lane_res;
            end
            for (int unsigned k = 1; k < STAGES; k++) begin
                if (load[k]) begin
                    v_q[k] <= v_q[k-1];
                    d_q[k] <= d_q[k-1];
                end
            end
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end

endmodule

// File: tb/tb_aoi112_pipe.sv
// Bench for aoi112_pipe: table vectors, mode sweep, latency, backpressure,
// counter/saturation, async reset, and randomized traffic against a queue model.
module tb_aoi112_pipe;

    localparam int unsigned W    = 4;
    localparam int unsigned MAXC = 255;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] mode = '0;
    logic [W-1:0] a1 = '0, b1 = '0, c1 = '0, c2 = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [W-1:0] out_data;
    logic       cnt_clr = 1'b0;
    logic [7:0] toggle_cnt;

    logic       s_in_valid = 1'b0;
    logic       s_in_ready;
    logic [W-1:0] s_a = '0;
    logic [W-1:0] s_zero = '0;
    logic       s_out_valid;
    logic [W-1:0] s_out_data;
    logic [1:0] s_cnt;

    always #5 clk = ~clk;

    aoi112_pipe #(.WIDTH(4), .STAGES(2), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .a1(a1), .b1(b1), .c1(c1), .c2(c2), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .cnt_clr(cnt_clr), .toggle_cnt(toggle_cnt)
    );

    aoi112_pipe #(.WIDTH(4), .STAGES(2), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .mode(2'd2),
        .a1(s_a), .b1(s_zero), .c1(s_zero), .c2(s_zero), .out_valid(s_out_valid),
        .out_ready(1'b1), .out_data(s_out_data), .cnt_clr(1'b0), .toggle_cnt(s_cnt)
    );

    typedef struct {
        logic [1:0]   m;
        logic [W-1:0] a, b, c, d;
        logic [W-1:0] exp;
    } vec_t;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] q[$];
    int           mcnt = 0;
    logic [W-1:0] mlast = '0;
    logic         last_in_ready;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_fn(input logic [1:0] m, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic [W-1:0] c,
                                            input logic [W-1:0] d);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            int ao, oa;
            ao = ((int'(a[i]) + int'(b[i]) + int'(c[i]) * int'(d[i])) > 0) ? 1 : 0;
            oa = ((int'(a[i]) * int'(b[i]) * (int'(c[i]) + int'(d[i]))) > 0) ? 1 : 0;
            case (m)
                2'd0:    r[i] = (ao == 0);
                2'd1:    r[i] = (oa == 0);
                2'd2:    r[i] = (ao == 1);
                default: r[i] = (oa == 1);
            endcase
        end
        return r;
    endfunction

    // Called at a falling edge with inputs already set; returns at the next falling edge.
    task automatic cyc();
        logic acc, fire;
        logic [W-1:0] od, e;
        #1;
        acc  = in_valid && in_ready;
        fire = out_valid && out_ready;
        od   = out_data;
        last_in_ready = in_ready;
        if (fire) begin
            chk("sb_nonempty", q.size() != 0, 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("sb_data", od, e);
            end
        end
        if (acc) q.push_back(ref_fn(mode, a1, b1, c1, c2));
        @(posedge clk);
        if (fire) begin
            if (!cnt_clr && od != mlast && mcnt < MAXC) mcnt++;
            mlast = od;
        end
        if (cnt_clr) mcnt = 0;
        @(negedge clk);
        chk("toggle_cnt", toggle_cnt, mcnt);
    endtask

    task automatic push(input logic [W-1:0] val);
        mode = 2'd2; a1 = val; b1 = '0; c1 = '0; c2 = '0; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        q.delete(); mcnt = 0; mlast = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[7];
        logic [W-1:0] combo, held;
        tbl[0] = '{2'd0, 4'h0, 4'h0, 4'hC, 4'hA, 4'h7};
        tbl[1] = '{2'd2, 4'h0, 4'h0, 4'hC, 4'hA, 4'h8};
        tbl[2] = '{2'd1, 4'h0, 4'h0, 4'hC, 4'hA, 4'hF};
        tbl[3] = '{2'd3, 4'h0, 4'h0, 4'hC, 4'hA, 4'h0};
        tbl[4] = '{2'd0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[5] = '{2'd3, 4'hF, 4'h5, 4'h3, 4'h0, 4'h1};
        tbl[6] = '{2'd1, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_toggle_cnt", toggle_cnt, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);

        // Table vectors, one at a time through an empty pipe
        for (int t = 0; t < 7; t++) begin
            mode = tbl[t].m; a1 = tbl[t].a; b1 = tbl[t].b; c1 = tbl[t].c; c2 = tbl[t].d;
            in_valid = 1'b1; out_ready = 1'b1;
            cyc();
            chk("tbl_lat_early", out_valid, 0);
            in_valid = 1'b0;
            cyc();
            chk("tbl_valid", out_valid, 1);
            chk("tbl_data", out_data, tbl[t].exp);
            cyc();
        end

        // Sweep all input combinations in every mode, back-to-back
        for (int n = 0; n < 64; n++) begin
            mode = 2'(n / 16);
            for (int i = 0; i < W; i++) begin
                combo = 4'((n + i * 5) % 16);
                a1[i] = combo[3]; b1[i] = combo[2]; c1[i] = combo[1]; c2[i] = combo[0];
            end
            in_valid = 1'b1;
            cyc();
        end
        drain(3);

        // Latency and throughput
        for (int i = 0; i < 10; i++) begin
            in_valid = (i < 8);
            mode = 2'($urandom_range(0, 3));
            a1 = 4'($urandom); b1 = 4'($urandom); c1 = 4'($urandom); c2 = 4'($urandom);
            cyc();
            if (i < 8) chk("thr_in_ready", last_in_ready, 1);
            chk("thr_out_valid", out_valid, (i >= 1 && i <= 8) ? 1 : 0);
        end
        drain(2);

        // Backpressure: fill, stall five cycles, release
        out_ready = 1'b0;
        push(4'h3);
        push(4'h9);
        mode = 2'd2; a1 = 4'h6; b1 = '0; c1 = '0; c2 = '0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("bp_in_ready", last_in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_data", out_data, 4'h3);
        end
        out_ready = 1'b1;
        cyc();
        drain(4);
        chk("bp_all_delivered", q.size(), 0);

        // Activity counter
        do_reset();
        out_ready = 1'b1;
        push(4'h0); push(4'h0); push(4'hF); push(4'hF); push(4'h3);
        drain(3);
        chk("cnt_seq", toggle_cnt, 2);
        push(4'hC);
        cyc();
        chk("clr_pre_valid", out_valid, 1);
        cnt_clr = 1'b1;
        cyc();
        cnt_clr = 1'b0;
        chk("cnt_clr", toggle_cnt, 0);
        push(4'hC);
        drain(3);
        chk("cnt_last_kept", toggle_cnt, 0);

        // Asynchronous reset with two vectors in flight
        do_reset();
        push(4'h5); push(4'hA); push(4'h5); push(4'hA);
        drain(3);
        chk("pre_rst_cnt", toggle_cnt, 4);
        out_ready = 1'b0;
        push(4'h1);
        push(4'h2);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_toggle_cnt", toggle_cnt, 0);
        chk("arst_in_ready", in_ready, 1);
        q.delete(); mcnt = 0; mlast = '0;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        push(4'h0);
        drain(3);
        chk("post_rst_same", toggle_cnt, 0);
        push(4'h1);
        drain(3);
        chk("post_rst_change", toggle_cnt, 1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            cnt_clr   = ($urandom_range(0, 31) == 0);
            mode = 2'($urandom_range(0, 3));
            a1 = 4'($urandom); b1 = 4'($urandom); c1 = 4'($urandom); c2 = 4'($urandom);
            cyc();
        end
        cnt_clr = 1'b0; out_ready = 1'b1;
        drain(4);
        chk("rand_drain", q.size(), 0);

        // Saturation on the narrow-counter instance
        for (int i = 0; i < 5; i++) begin
            held = (i % 2 == 1) ? 4'hA : 4'h5;
            s_a = held;
            s_in_valid = 1'b1;
            @(negedge clk);
        end
        s_in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("sat_cnt", s_cnt, 3);
        chk("sat_last_data", s_out_data, 4'h5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aoi112_pipe.md
Name: aoi112_pipe

Overview:
- Parametrised, registered successor to the single-bit AOI112 library cell; used in ADPLL datapath/TDC decode where a clocked, lane-wide complex-gate function is needed.
- Computes a per-lane 4-input complex gate over WIDTH lanes. Four runtime-selectable function modes.
- Result travels through a STAGES-deep valid/ready pipeline with backpressure.
- Includes a saturating output-activity (vector change) counter for toggle-rate characterisation.

Parameters:
- WIDTH, 4: number of lanes; each lane has bits a1, b1, c1, c2.
- STAGES, 2: pipeline register stages, >=1; fire-to-output latency in cycles.
- CNT_W, 8: width of the activity counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  input vector valid.
- in_ready  out  1  input accepted when in_valid & in_ready.
- mode  in  2  function select, sampled with the input vector.
- a1  in  WIDTH  lane A1 inputs.
- b1  in  WIDTH  lane B1 inputs.
- c1  in  WIDTH  lane C1 inputs.
- c2  in  WIDTH  lane C2 inputs.
- out_valid  out  1  output vector valid.
- out_ready  in  1  downstream ready.
- out_data  out  WIDTH  lane results.
- cnt_clr  in  1  synchronous clear of the activity counter.
- toggle_cnt  out  CNT_W  saturating count of changed output vectors.

Behaviour:
- Function per lane i, evaluated at input acceptance:
  - mode 0, AOI112: ~(a1|b1|(c1&c2))
  - mode 1, OAI112: ~(a1&b1&(c1|c2))
  - mode 2, AO112: a1|b1|(c1&c2)
  - mode 3, OA112: a1&b1&(c1|c2)
- Only the computed WIDTH-bit result enters the pipeline. mode is not retained.
- Pipeline stages k = 0..STAGES-1, each holding valid bit v[k] and data d[k].
  - Last stage loads when ~v[last] | out_ready.
  - Stage k<last loads when ~v[k] | load[k+1].
  - Stage 0 loads from the inputs.
  - A loading stage takes the previous stage's valid/data. A bubble propagates as valid=0.
- in_ready = load[0], combinational from out_ready through the chain; no skid buffer.
- out_valid = v[last], out_data = d[last].
- Data is held stable while out_valid & ~out_ready.
- Latency: a vector accepted at edge n appears on out_valid/out_data after edge n+STAGES-1. With out_ready=1 this is visible in the cycle following that edge.
- Throughput: 1 vector/cycle with out_ready=1.
- Full pipe with out_ready=0: in_ready=0, contents frozen, no loss, no duplication.
- Full pipe with out_ready=1 and in_valid=1: output fires and a new input is accepted in the same cycle.
- Activity counter, on output fire (out_valid & out_ready):
  - If out_data != last_out, toggle_cnt increments, saturating at 2^CNT_W-1 with no wrap.
  - last_out <= out_data on every fire.
- cnt_clr:
  - Sets toggle_cnt to 0 next cycle and has priority over a simultaneous increment.
  - last_out still updates on a simultaneous fire.
  - last_out is never cleared by cnt_clr.
- Reset (asynchronous, any time including mid-transfer) forces:
  - all v[k]=0 and d[k]=0,
  - out_valid=0, out_data=0,
  - toggle_cnt=0, last_out=0.
  - in_ready therefore reads 1 after reset.
  - In-flight vectors are discarded.
- No X propagation on out_data when out_valid=0. Stage data resets to 0.

Test Plan:
- Mode truth table: WIDTH=4, out_ready=1, mode 0, a1=4'b0000, b1=4'b0000, c1=4'b1100, c2=4'b1010 -> out_data=4'b0111 two cycles later. Same inputs with mode 2 -> 4'b1000. With mode 1 -> 4'b1111. Sweep all 16 input combos x 4 modes against a reference model.
- Latency/throughput: 8 back-to-back vectors with out_ready=1 -> first out_valid 2 cycles after first accept, then 8 consecutive valid cycles in order, in_ready stays 1.
- Backpressure: fill pipe, hold out_ready=0 for 5 cycles -> in_ready=0, out_data constant. Release -> all vectors delivered in order, none lost or duplicated.
- Counter: outputs 0x0, 0x0, 0xF, 0xF, 0x3 -> toggle_cnt=2. Then pulse cnt_clr concurrent with a changing fire -> toggle_cnt=0.
- Saturation: CNT_W=2, 5 alternating outputs 0x5/0xA -> toggle_cnt sticks at 3.
- Reset mid-operation: assert rst asynchronously with 2 vectors in flight and toggle_cnt=4 -> immediately out_valid=0, out_data=0, toggle_cnt=0. After release, first output compared against last_out=0.
